// File: rtl/br_resolve_unit_if.sv
// Execute-stage <-> branch-resolution unit bundle.
// Signal names carry the unit's point of view: *_i are driven by the
// execute/fetch side (master), *_o are driven by br_resolve_unit (slave).
interface br_resolve_unit_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int BR_OP_WIDTH = 3
);

  // execute-stage request
  logic                   valid_i;
  logic                   flush_i;
  logic                   stall_i;
  logic                   is_branch_i;
  logic                   is_conditional_i;
  logic [BR_OP_WIDTH-1:0] br_op_i;
  logic [DATA_WIDTH-1:0]  rs1_d_i;
  logic [DATA_WIDTH-1:0]  rs2_d_i;
  logic [DATA_WIDTH-1:0]  alu_d_i;
  logic [DATA_WIDTH-1:0]  old_pc_i;
  logic [DATA_WIDTH-1:0]  imm_i;
  logic                   pred_taken_i;

  // fetch-stage prediction lookup
  logic [DATA_WIDTH-1:0]  fetch_pc_i;
  logic                   pred_taken_o;

  // registered resolution result
  logic                   valid_o;
  logic [DATA_WIDTH-1:0]  new_pc_o;
  logic [DATA_WIDTH-1:0]  link_o;
  logic                   taken_o;
  logic                   mispredict_o;

  modport master (
    output valid_i, flush_i, stall_i, is_branch_i, is_conditional_i, br_op_i,
           rs1_d_i, rs2_d_i, alu_d_i, old_pc_i, imm_i, pred_taken_i, fetch_pc_i,
    input  pred_taken_o, valid_o, new_pc_o, link_o, taken_o, mispredict_o
  );

  modport slave (
    input  valid_i, flush_i, stall_i, is_branch_i, is_conditional_i, br_op_i,
           rs1_d_i, rs2_d_i, alu_d_i, old_pc_i, imm_i, pred_taken_i, fetch_pc_i,
    output pred_taken_o, valid_o, new_pc_o, link_o, taken_o, mispredict_o
  );

endinterface

// File: rtl/br_resolve_unit.sv
// Registered branch-resolution unit for the RV32I execute stage.
// Evaluates the six conditional compares, picks the next PC, produces the
// link value and flags mispredicts one clock after an accepted instruction.
//
// Optional feature macro: BR_PREDICT_EN
//   defined   - a table of 2-bit saturating counters (BHT) is looked up
//               combinationally by fetch and trained by resolved Bxx.
//   undefined - no BHT storage, pred_taken_o is tied to 0 (static
//               not-taken); fetch_pc_i is ignored.
module br_resolve_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int BR_OP_WIDTH = 3,
  parameter int BHT_DEPTH   = 64,
  parameter int BHT_IDX_W   = 6
) (
  input logic             clk_i,
  input logic             rstn_i,
  br_resolve_unit_if.slave br_if
);

  localparam logic [BR_OP_WIDTH-1:0] OP_EQ  = BR_OP_WIDTH'(0);
  localparam logic [BR_OP_WIDTH-1:0] OP_NE  = BR_OP_WIDTH'(1);
  localparam logic [BR_OP_WIDTH-1:0] OP_LT  = BR_OP_WIDTH'(2);
  localparam logic [BR_OP_WIDTH-1:0] OP_GE  = BR_OP_WIDTH'(3);
  localparam logic [BR_OP_WIDTH-1:0] OP_LTU = BR_OP_WIDTH'(4);
  localparam logic [BR_OP_WIDTH-1:0] OP_GEU = BR_OP_WIDTH'(5);

  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

  // accept qualification
  logic accept;
  logic is_cond_br;

  // combinational resolution of the current input
  logic                  cond;
  logic                  taken;
  logic                  mispredict;
  logic [DATA_WIDTH-1:0] seq_pc;
  logic [DATA_WIDTH-1:0] br_target;
  logic [DATA_WIDTH-1:0] jump_target;
  logic [DATA_WIDTH-1:0] next_pc;

  // output registers
  logic                  valid_q,      valid_d;
  logic [DATA_WIDTH-1:0] new_pc_q,     new_pc_d;
  logic [DATA_WIDTH-1:0] link_q,       link_d;
  logic                  taken_q,      taken_d;
  logic                  mispredict_q, mispredict_d;

  assign accept     = br_if.valid_i & ~br_if.flush_i & ~br_if.stall_i;
  assign is_cond_br = br_if.is_branch_i & br_if.is_conditional_i;

  // Six-way compare; LT/GE are signed, LTU/GEU unsigned, codes 6-7 never taken
  always_comb begin
    cond = 1'b0;
    case (br_if.br_op_i)
      OP_EQ:   cond = (br_if.rs1_d_i == br_if.rs2_d_i);
      OP_NE:   cond = (br_if.rs1_d_i != br_if.rs2_d_i);
      OP_LT:   cond = ($signed(br_if.rs1_d_i) <  $signed(br_if.rs2_d_i));
      OP_GE:   cond = ($signed(br_if.rs1_d_i) >= $signed(br_if.rs2_d_i));
      OP_LTU:  cond = (br_if.rs1_d_i <  br_if.rs2_d_i);
      OP_GEU:  cond = (br_if.rs1_d_i >= br_if.rs2_d_i);
      default: cond = 1'b0;
    endcase
  end

  // Candidate PCs; all sums wrap modulo 2^DATA_WIDTH
  assign seq_pc      = br_if.old_pc_i + PC_STEP;
  assign br_target   = br_if.old_pc_i + br_if.imm_i;
  assign jump_target = {br_if.alu_d_i[DATA_WIDTH-1:1], 1'b0};

  // Taken / next-PC / mispredict selection for the instruction in execute
  always_comb begin
    taken      = br_if.is_branch_i & (~br_if.is_conditional_i | cond);
    next_pc    = seq_pc;
    mispredict = 1'b0;
    if (br_if.is_branch_i) begin
      if (!br_if.is_conditional_i) begin
        // jumps always redirect: fetch never predicts their target
        next_pc    = jump_target;
        mispredict = 1'b1;
      end else begin
        next_pc    = taken ? br_target : seq_pc;
        mispredict = taken ^ br_if.pred_taken_i;
      end
    end
  end

  // Output register next-state: load on accept, drop valid/taken on bubbles, hold on stall
  always_comb begin
    valid_d      = valid_q;
    new_pc_d     = new_pc_q;
    link_d       = link_q;
    taken_d      = taken_q;
    mispredict_d = mispredict_q;
    if (!br_if.stall_i) begin
      if (accept) begin
        valid_d      = 1'b1;
        new_pc_d     = next_pc;
        link_d       = seq_pc;
        taken_d      = taken;
        mispredict_d = mispredict;
      end else begin
        // mispredict keeps its old value but is meaningless without valid_o
        valid_d = 1'b0;
        taken_d = 1'b0;
      end
    end
  end

  // Output registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q      <= 1'b0;
      new_pc_q     <= '0;
      link_q       <= '0;
      taken_q      <= 1'b0;
      mispredict_q <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      new_pc_q     <= new_pc_d;
      link_q       <= link_d;
      taken_q      <= taken_d;
      mispredict_q <= mispredict_d;
    end
  end

  assign br_if.valid_o      = valid_q;
  assign br_if.new_pc_o     = new_pc_q;
  assign br_if.link_o       = link_q;
  assign br_if.taken_o      = taken_q;
  assign br_if.mispredict_o = mispredict_q;

`ifdef BR_PREDICT_EN

  // Word-aligned PCs index the table; upper PC bits alias onto the same entry
  logic                 train_en;
  logic [BHT_IDX_W-1:0] train_idx;
  logic [BHT_IDX_W-1:0] fetch_idx;
  logic [1:0]           train_cnt;
  logic [1:0]           bht_q [BHT_DEPTH];
  logic [1:0]           bht_d [BHT_DEPTH];

  assign train_en  = accept & is_cond_br;
  assign train_idx = br_if.old_pc_i[BHT_IDX_W+1:2];
  assign fetch_idx = br_if.fetch_pc_i[BHT_IDX_W+1:2];
  assign train_cnt = bht_q[train_idx];

  // Saturating counter update for the resolving conditional branch
  always_comb begin
    bht_d = bht_q;
    if (train_en) begin
      if (taken) begin
        if (train_cnt != 2'b11) bht_d[train_idx] = train_cnt + 2'b01;
      end else begin
        if (train_cnt != 2'b00) bht_d[train_idx] = train_cnt - 2'b01;
      end
    end
  end

  // Counter storage; reset leaves every entry weakly not-taken
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
    end else begin
      bht_q <= bht_d;
    end
  end

  // Lookup reads the registered table, so a same-cycle update is not visible yet
  assign br_if.pred_taken_o = bht_q[fetch_idx][1];

`else

  // Static not-taken prediction
  assign br_if.pred_taken_o = 1'b0;

`endif

endmodule

// File: tb/tb_br_resolve_unit.sv
// Self-checking bench for br_resolve_unit: directed cases followed by
// randomized traffic checked against a behavioural model of the resolver
// and (when BR_PREDICT_EN is defined) of the counter table.
module tb_br_resolve_unit;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  br_resolve_unit_if #(.DATA_WIDTH(32), .BR_OP_WIDTH(3)) bif ();

  br_resolve_unit #(
    .DATA_WIDTH(32), .BR_OP_WIDTH(3), .BHT_DEPTH(64), .BHT_IDX_W(6)
  ) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .br_if (bif)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  logic        m_valid, m_taken, m_misp;
  logic [31:0] m_new_pc, m_link;
  int          ctr [64];

  function automatic longint sval(input logic [31:0] x);
    longint v;
    v = longint'({32'd0, x});
    if (x[31]) v = v - 64'sh1_0000_0000;
    return v;
  endfunction

  function automatic bit cond_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint ua, ub;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (op)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd2:    return sval(a) <  sval(b);
      3'd3:    return sval(a) >= sval(b);
      3'd4:    return ua <  ub;
      3'd5:    return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic exp_pred(input logic [31:0] pc);
`ifdef BR_PREDICT_EN
    return ctr[pc[7:2]] >= 2;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_taken = 0; m_misp = 0; m_new_pc = '0; m_link = '0;
    for (int i = 0; i < 64; i++) ctr[i] = 1;
  endtask

  // model of one rising edge using the inputs currently applied
  task automatic model_edge();
    bit tk;
    logic [31:0] pc4;
    int idx;
    if (bif.stall_i) return;
    if (!bif.valid_i || bif.flush_i) begin
      m_valid = 0;
      m_taken = 0;
      return;
    end
    tk  = bif.is_branch_i && (!bif.is_conditional_i ||
          cond_of(bif.br_op_i, bif.rs1_d_i, bif.rs2_d_i));
    pc4 = bif.old_pc_i + 32'd4;
    m_valid = 1;
    m_taken = tk;
    m_link  = pc4;
    if (!bif.is_branch_i) begin
      m_new_pc = pc4;
      m_misp   = 0;
    end else if (!bif.is_conditional_i) begin
      m_new_pc = bif.alu_d_i & ~32'd1;
      m_misp   = 1;
    end else begin
      m_new_pc = tk ? bif.old_pc_i + bif.imm_i : pc4;
      m_misp   = tk ^ bif.pred_taken_i;
      idx = int'(bif.old_pc_i[7:2]);
      if (tk) ctr[idx] = (ctr[idx] == 3) ? 3 : ctr[idx] + 1;
      else    ctr[idx] = (ctr[idx] == 0) ? 0 : ctr[idx] - 1;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, bif.valid_o, m_valid);
    check({tag, ".new_pc"}, bif.new_pc_o, m_new_pc);
    check({tag, ".link"}, bif.link_o, m_link);
    check({tag, ".taken"}, bif.taken_o, m_taken);
    check({tag, ".misp"}, bif.mispredict_o, m_misp);
  endtask

  task automatic drive(input logic v, input logic fl, input logic st, input logic br,
                       input logic cnd, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] alu, input logic [31:0] pc,
                       input logic [31:0] imm, input logic pt, input logic [31:0] fpc);
    bif.valid_i = v;  bif.flush_i = fl; bif.stall_i = st;
    bif.is_branch_i = br; bif.is_conditional_i = cnd; bif.br_op_i = op;
    bif.rs1_d_i = a; bif.rs2_d_i = b; bif.alu_d_i = alu;
    bif.old_pc_i = pc; bif.imm_i = imm; bif.pred_taken_i = pt; bif.fetch_pc_i = fpc;
  endtask

  task automatic idle(input logic [31:0] fpc);
    drive(0, 0, 0, 0, 0, 3'd0, '0, '0, '0, '0, '0, 0, fpc);
  endtask

  // one clock: check lookup before the edge, model the edge, check registers after
  task automatic tick(input string tag);
    @(negedge clk);
    check({tag, ".pred"}, bif.pred_taken_o, exp_pred(bif.fetch_pc_i));
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  function automatic logic [31:0] pick_op();
    case ($urandom % 8)
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'd2;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] pick_pc();
    if ($urandom % 4 == 0) return $urandom;
    return 32'h80 + (($urandom % 4) << 8) + (($urandom % 4) << 2);
  endfunction

  logic [31:0] rpc, rfpc;

  initial begin
    rstn = 1'b0;
    idle(32'h0);
    model_reset();
    #12;
    check_outputs("reset");
    check("reset.pred", bif.pred_taken_o, 1'b0);
    @(negedge clk);
    rstn = 1'b1;

    // BEQ equal operands, predicted not-taken
    drive(1, 0, 0, 1, 1, 3'd0, 32'd5, 32'd5, '0, 32'h100, 32'h20, 0, 32'h100);
    tick("beq");
    check("beq.const_pc", bif.new_pc_o, 32'h120);
    check("beq.const_misp", bif.mispredict_o, 1'b1);

    // BLT signed: -1 < 1 taken
    drive(1, 0, 0, 1, 1, 3'd2, 32'hFFFF_FFFF, 32'd1, '0, 32'h200, 32'h40, 1, 32'h200);
    tick("blt");
    check("blt.const_taken", bif.taken_o, 1'b1);
    check("blt.const_pc", bif.new_pc_o, 32'h240);

    // BLTU same operands: not taken
    drive(1, 0, 0, 1, 1, 3'd4, 32'hFFFF_FFFF, 32'd1, '0, 32'h200, 32'h40, 1, 32'h200);
    tick("bltu");
    check("bltu.const_taken", bif.taken_o, 1'b0);
    check("bltu.const_pc", bif.new_pc_o, 32'h204);

    // JALR target LSB cleared
    drive(1, 0, 0, 1, 0, 3'd0, '0, '0, 32'h2003, 32'h40, '0, 0, 32'h40);
    tick("jalr");
    check("jalr.const_pc", bif.new_pc_o, 32'h2002);
    check("jalr.const_link", bif.link_o, 32'h44);
    check("jalr.const_misp", bif.mispredict_o, 1'b1);

    // non-branch at top of address space wraps
    drive(1, 0, 0, 0, 0, 3'd0, '0, '0, 32'h1234, 32'hFFFF_FFFC, 32'h8, 0, 32'h0);
    tick("wrap");
    check("wrap.const_pc", bif.new_pc_o, 32'h0);

    // stall for 3 clocks with a valid taken conditional: nothing moves
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 1, 1, 3'd1, 32'd1, 32'd2, '0, 32'h80, 32'h10, 0, 32'h80);
      tick("stall");
      check("stall.const_valid", bif.valid_o, 1'b1);
      check("stall.const_pc", bif.new_pc_o, 32'h0);
    end

    // flush of a taken conditional: bubble and no training
    drive(1, 1, 0, 1, 1, 3'd0, 32'd7, 32'd7, '0, 32'h80, 32'h10, 0, 32'h80);
    tick("flush");
    check("flush.const_valid", bif.valid_o, 1'b0);
    check("flush.const_link", bif.link_o, 32'h0);

    // three taken BEQ at 0x80: counter 1->2->3->3
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 1, 1, 3'd0, 32'd9, 32'd9, '0, 32'h80, 32'h40, 0, 32'h80);
      tick("train");
    end
    idle(32'h180);
    #1;
`ifdef BR_PREDICT_EN
    check("alias.const_pred", bif.pred_taken_o, 1'b1);
`else
    check("alias.const_pred", bif.pred_taken_o, 1'b0);
`endif
    tick("alias");

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      rpc  = pick_pc();
      rfpc = ($urandom % 2 == 0) ? rpc : pick_pc();
      drive(($urandom % 4) != 0, ($urandom % 8) == 0, ($urandom % 6) == 0,
            ($urandom % 4) != 0, ($urandom % 3) != 0, 3'($urandom % 8),
            pick_op(), pick_op(), $urandom, rpc, $urandom, 1'($urandom % 2), rfpc);
      tick("rand");
    end

    // reset mid-stream clears outputs and table immediately
    drive(1, 0, 0, 1, 1, 3'd0, 32'd3, 32'd3, '0, 32'h84, 32'h40, 0, 32'h84);
    tick("pre_rst");
    #3;
    rstn = 1'b0;
    model_reset();
    #1;
    check_outputs("midrst");
    for (int i = 0; i < 4; i++) begin
      bif.fetch_pc_i = 32'h80 + (i << 8) + (i << 2);
      #1;
      check("midrst.pred", bif.pred_taken_o, 1'b0);
    end
    @(negedge clk);
    rstn = 1'b1;
    drive(1, 0, 0, 1, 1, 3'd5, 32'd4, 32'd4, '0, 32'h300, 32'h100, 0, 32'h80);
    tick("post_rst");
    idle(32'h80);
    tick("post_rst_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
